audio_playback_ctrl: RTL



---
 rtl/audio_pkg.sv | 18 +
 rtl/sample_tick_gen.sv | 31 +++
 rtl/audio_playback_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and default constants for the game-audio playback path.
// Optional clip looping is enabled with AUDIO_PLAYBACK_LOOP_EN.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSE
  } audio_state_e;

  localparam int AUDIO_CLK_HZ    = 100_000_000;
  localparam int AUDIO_SAMPLE_HZ = 44_100;
  localparam int AUDIO_CLIP_LEN  = 176_400;
  localparam int AUDIO_SAMPLE_W  = 16;
  localparam int AUDIO_ADDR_W    = 18;
  localparam int AUDIO_ACC_W     = 28;

endpackage

// File: rtl/sample_tick_gen.sv
// Phase-accumulator sample tick: exact average rate SAMPLE_HZ from CLK_HZ.
// Free-running; only rst disturbs the cadence.
module sample_tick_gen
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = AUDIO_CLK_HZ,
  parameter int SAMPLE_HZ = AUDIO_SAMPLE_HZ,
  parameter int ACC_W     = AUDIO_ACC_W
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [ACC_W-1:0] INC = ACC_W'(SAMPLE_HZ);
  localparam logic [ACC_W-1:0] MOD = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q, acc_d, sum;

  always_comb begin
    sum   = acc_q + INC;
    tick  = (sum >= MOD);
    acc_d = tick ? (sum - MOD) : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/audio_playback_ctrl.sv
// Sample-ROM playback sequencer: tick-paced fetch, registered sample + strobe.
// Define AUDIO_PLAYBACK_LOOP_EN to add the loop input (wrap instead of stop).
module audio_playback_ctrl
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = AUDIO_CLK_HZ,
  parameter int SAMPLE_HZ = AUDIO_SAMPLE_HZ,
  parameter int CLIP_LEN  = AUDIO_CLIP_LEN,
  parameter int ADDR_W    = AUDIO_ADDR_W,
  parameter int ACC_W     = AUDIO_ACC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      stop,
`ifdef AUDIO_PLAYBACK_LOOP_EN
  input  logic                      loop,
`endif
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [AUDIO_SAMPLE_W-1:0] rom_data,
  output logic [AUDIO_SAMPLE_W-1:0] sample_out,
  output logic                      sample_valid,
  output logic                      busy,
  output logic                      paused,
  output logic                      done,
  output logic [ADDR_W-1:0]         position
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CLIP_LEN - 1);

  audio_state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [AUDIO_SAMPLE_W-1:0] sample_q, sample_d;
  logic valid_q, valid_d;
  logic done_q, done_d;
  logic pend_q, pend_d;
  logic tick;
  logic loop_en;

`ifdef AUDIO_PLAYBACK_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  sample_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ),
    .ACC_W    (ACC_W)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    pend_d   = 1'b0;
    // A launched fetch always lands, even if pause arrived meanwhile
    if (pend_q) begin
      sample_d = rom_data;
      valid_d  = 1'b1;
      if (ptr_q == LAST) begin
        ptr_d  = '0;
        done_d = 1'b1;
        if (!loop_en) state_d = ST_IDLE;
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end
    if (tick && state_q == ST_PLAY) pend_d = 1'b1;
    if (stop) begin
      state_d  = ST_IDLE;
      ptr_d    = '0;
      sample_d = '0;
      pend_d   = 1'b0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
    end else if (start) begin
      state_d = ST_PLAY;
      if (state_q == ST_IDLE) begin
        ptr_d    = '0;
        sample_d = '0;
      end
    end else if (pause && state_d == ST_PLAY) begin
      state_d = ST_PAUSE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
    end
  end

  assign rom_addr     = ptr_q;
  assign position     = ptr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign done         = done_q;
  assign busy         = (state_q != ST_IDLE);
  assign paused       = (state_q == ST_PAUSE);

endmodule
